// File: rtl/instruction_fetch_stage_if.sv
// Bundle of the fetch stage's memory-side, redirect and decode-side handshakes.
// The master modport is the fetch stage; the slave modport is its environment.
interface instruction_fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch front end: PC sequencing, bounded outstanding fetches, in-order
// instruction queue to decode, and redirect flush that discards stale responses.
module instruction_fetch_stage_chk #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          resp_valid,
    input logic [CW-1:0] count,
    input logic [CW-1:0] live,
    input logic [CW-1:0] drop
);
    a_resp_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid |-> ((live != {CW{1'b0}}) || (drop != {CW{1'b0}})))
        else $error("imem response with no outstanding request");

    a_queue_room: assert property (@(posedge clk) disable iff (!rst_n)
        (resp_valid && (drop == {CW{1'b0}}) && (live != {CW{1'b0}})) |-> (32'(count) < DEPTH))
        else $error("imem response arrived with instruction queue full");
endmodule

module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic                       clk,
    input logic                       rst_n,
    instruction_fetch_stage_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(DEPTH - 1)) begin
            r = PW'(0);
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    logic [31:0]   pc_r;
    logic          running_r;
    logic [CW-1:0] count_r, live_r, drop_r;
    logic [PW-1:0] q_wr_ptr_r, q_rd_ptr_r, af_wr_ptr_r, af_rd_ptr_r;
    logic [31:0]   q_instr_r [DEPTH];
    logic [31:0]   q_pc_r    [DEPTH];
    logic [31:0]   af_addr_r [DEPTH];

    logic        out_valid_s, pop_s, req_valid_s, accept_s;
    logic        resp_s, resp_drop_s, resp_keep_s;
    logic [31:0] occ_s;

    // handshake decode; a same-cycle pop frees a slot for a new request
    always_comb begin
        out_valid_s = (count_r != {CW{1'b0}});
        pop_s       = out_valid_s & bus.out_ready;
        occ_s       = 32'(count_r) + 32'(live_r) + 32'(drop_r) - 32'(pop_s);
        req_valid_s = running_r & ~bus.redirect_valid & (occ_s < 32'(DEPTH));
        accept_s    = req_valid_s & bus.imem_req_ready;
        resp_s      = bus.imem_resp_valid & ((live_r != {CW{1'b0}}) | (drop_r != {CW{1'b0}}));
        resp_drop_s = resp_s & (drop_r != {CW{1'b0}});
        resp_keep_s = resp_s & (drop_r == {CW{1'b0}}) & ~bus.redirect_valid;
    end

    // PC, occupancy counters and queue/address-FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= RESET_PC;
            running_r   <= 1'b0;
            count_r     <= {CW{1'b0}};
            live_r      <= {CW{1'b0}};
            drop_r      <= {CW{1'b0}};
            q_wr_ptr_r  <= {PW{1'b0}};
            q_rd_ptr_r  <= {PW{1'b0}};
            af_wr_ptr_r <= {PW{1'b0}};
            af_rd_ptr_r <= {PW{1'b0}};
        end else begin
            running_r <= 1'b1;
            if (bus.redirect_valid) begin
                // everything still in flight becomes a response to throw away
                pc_r       <= bus.redirect_pc & ~32'd3;
                count_r    <= {CW{1'b0}};
                q_wr_ptr_r <= {PW{1'b0}};
                q_rd_ptr_r <= {PW{1'b0}};
                live_r     <= {CW{1'b0}};
                drop_r     <= drop_r + live_r - CW'(resp_s);
            end else begin
                if (accept_s) begin
                    pc_r <= pc_r + 32'd4;
                end else begin
                    pc_r <= pc_r;
                end
                count_r <= count_r + CW'(resp_keep_s) - CW'(pop_s);
                live_r  <= live_r + CW'(accept_s) - CW'(resp_s & ~resp_drop_s);
                drop_r  <= drop_r - CW'(resp_drop_s);
                if (resp_keep_s) begin
                    q_wr_ptr_r <= ptr_inc(q_wr_ptr_r);
                end else begin
                    q_wr_ptr_r <= q_wr_ptr_r;
                end
                if (pop_s) begin
                    q_rd_ptr_r <= ptr_inc(q_rd_ptr_r);
                end else begin
                    q_rd_ptr_r <= q_rd_ptr_r;
                end
            end
            if (accept_s) begin
                af_wr_ptr_r <= ptr_inc(af_wr_ptr_r);
            end else begin
                af_wr_ptr_r <= af_wr_ptr_r;
            end
            if (resp_s) begin
                af_rd_ptr_r <= ptr_inc(af_rd_ptr_r);
            end else begin
                af_rd_ptr_r <= af_rd_ptr_r;
            end
        end
    end

    // instruction queue and outstanding-address FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_instr_r[i] <= 32'd0;
                q_pc_r[i]    <= 32'd0;
                af_addr_r[i] <= 32'd0;
            end
        end else begin
            if (resp_keep_s) begin
                q_instr_r[q_wr_ptr_r] <= bus.imem_resp_data;
                q_pc_r[q_wr_ptr_r]    <= af_addr_r[af_rd_ptr_r];
            end
            if (accept_s) begin
                af_addr_r[af_wr_ptr_r] <= pc_r;
            end
        end
    end

    // decode-facing fields read zero whenever the queue is empty
    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = pc_r;
    assign bus.out_valid      = out_valid_s;
    assign bus.out_instr      = out_valid_s ? q_instr_r[q_rd_ptr_r] : 32'd0;
    assign bus.out_pc         = out_valid_s ? q_pc_r[q_rd_ptr_r] : 32'd0;
    assign bus.out_pc_plus4   = out_valid_s ? (q_pc_r[q_rd_ptr_r] + 32'd4) : 32'd0;

    instruction_fetch_stage_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .resp_valid (bus.imem_resp_valid),
        .count      (count_r),
        .live       (live_r),
        .drop       (drop_r)
    );
endmodule
